// File: rtl/acl_ctrl_pkg.sv
// rtl/acl_ctrl_pkg.sv - shared state encoding and default parameters for acl_fifo_ctrl
package acl_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } acl_state_t;

  localparam int DEF_MAX_FRAMES = 4;
  localparam int DEF_DEC_DEPTH  = 4;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/acl_dec_queue.sv
// rtl/acl_dec_queue.sv - 1-bit decision FIFO; a push while full is dropped unless a pop frees the slot
module acl_dec_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/acl_fifo_ctrl.sv
// rtl/acl_fifo_ctrl.sv - ACL forward/drop sequencer for a packet FIFO; ACL_STATS_EN enables fwd/drop counters
module acl_fifo_ctrl
  import acl_ctrl_pkg::*;
#(
  parameter int MAX_FRAMES = DEF_MAX_FRAMES,
  parameter int DEC_DEPTH  = DEF_DEC_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_rxd_tvalid,
  input  logic                            i_rxd_tlast,
  output logic                            o_rxd_tready,
  input  logic                            i_fifo_full,
  input  logic                            i_rd_tlast,
  output logic                            o_rd_valid,
  output logic                            o_fifo_invalid,
  input  logic                            i_tx_tready,
  input  logic                            i_acl_valid,
  input  logic                            i_acl_permit,
  output logic [$clog2(MAX_FRAMES+1)-1:0] o_frame_cnt,
  output logic [CNT_W-1:0]                o_fwd_cnt,
  output logic [CNT_W-1:0]                o_drop_cnt,
  output logic                            o_dec_ovf
);

  localparam int FC_W = $clog2(MAX_FRAMES + 1);

  acl_state_t      state;
  logic [FC_W-1:0] frame_cnt;
  logic            wr_done;
  logic            rd_done;
  logic            dec_pop;
  logic            dec_head;
  logic            dec_empty;
  logic            dec_full;

  assign o_frame_cnt    = frame_cnt;
  assign o_rxd_tready   = !i_fifo_full && (frame_cnt < FC_W'(MAX_FRAMES));
  assign o_rd_valid     = ((state == ST_FWD) && i_tx_tready) || (state == ST_DROP);
  assign o_fifo_invalid = (state == ST_DROP);
  assign wr_done        = i_rxd_tvalid && o_rxd_tready && i_rxd_tlast;
  assign rd_done        = o_rd_valid && i_rd_tlast;
  // Decisions only apply to frames already fully buffered.
  assign dec_pop        = (state == ST_IDLE) && (frame_cnt != '0) && !dec_empty;

  acl_dec_queue #(.DEPTH(DEC_DEPTH)) u_dec_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (i_acl_valid),
    .din   (i_acl_permit),
    .pop   (dec_pop),
    .dout  (dec_head),
    .empty (dec_empty),
    .full  (dec_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:         if (dec_pop) state <= dec_head ? ST_FWD : ST_DROP;
        ST_FWD, ST_DROP: if (rd_done) state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      o_dec_ovf <= 1'b0;
    end else begin
      if (wr_done && !rd_done)
        frame_cnt <= frame_cnt + 1'b1;
      else if (rd_done && !wr_done)
        frame_cnt <= frame_cnt - 1'b1;
      if (i_acl_valid && dec_full && !dec_pop)
        o_dec_ovf <= 1'b1;
    end
  end

`ifdef ACL_STATS_EN
  logic fwd_done;
  logic drop_done;

  assign fwd_done  = rd_done && (state == ST_FWD);
  assign drop_done = rd_done && (state == ST_DROP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_fwd_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (fwd_done && (o_fwd_cnt != '1))
        o_fwd_cnt <= o_fwd_cnt + 1'b1;
      if (drop_done && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end
`else
  assign o_fwd_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule
